clz_encoder: RTL and testbench
==============================

# clz_encoder

Counts leading zeros of a 32-bit word and returns the count as a 6-bit value, 0–32, with 32 for an all-zero input. It is the bit-count primitive for the Zbb `clz` and `ctz` instructions in the RV32IM_Zbb execute stage. `ctz` reuses the block by feeding it the bit-reversed operand (input bit i driven from operand bit 31−i); reversal is done by the caller. The result is registered, so the block sits at a pipeline boundary.

## Interface
Parameters:
- none; data width fixed at 32 bits, count width fixed at 6 bits (constants in shared package).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `data_in` is valid this cycle.
- `data_in`  in  32  operand; bit 31 is the MSB.
- `out_valid`  out  1  `count` and `zero` are valid.
- `count`  out  6  number of leading zeros of the captured operand, 0..32.
- `zero`  out  1  captured operand was all zeros; equals `count[5]`.

## Operation
- `count` = number of consecutive 0 bits starting at bit 31 and moving downward, stopping at the first 1.
  - `data_in == 0` → `count = 32` (6'b100000), `zero = 1`.
  - Bit 31 set → `count = 0`.
  - `count[5]` is set only for the all-zero case.
- Capture rule:
  - When `in_valid = 1`, the combinational result is captured on the next rising `clk`.
  - When `in_valid = 0`, `count` and `zero` hold their previous values and `out_valid` drops to 0.
- No backpressure. The consumer must accept the result in the cycle `out_valid` is high.
- `data_in` is purely combinational into the capture registers. There is no internal state besides the output registers.
- X on `data_in` while `in_valid = 0` must not propagate to the outputs.

## Timing
- Latency 1 cycle: an operand presented with `in_valid` at edge N gives its result and `out_valid` after edge N+1.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Reset (`rst_n` low, asynchronous assert): `out_valid = 0`, `count = 0`, `zero = 0` immediately, regardless of `clk`.
- Reset release is synchronous to the next `clk` edge. The first capture occurs on the first edge at which `rst_n = 1` and `in_valid = 1`.
- Reset asserted while an operand is in flight: that result is discarded, `out_valid = 0`.
- Critical path: a 32→6 priority encode. Implement it as a tree of log depth, not a 32-deep priority chain.

## Structure
- Shared package `zbb_pkg`:
  - `XLEN = 32`
  - `CLZ_W = 6`
  - type `clz_cnt_t` (logic [5:0])
- Sub-module `clz_nibble`:
  - Input: 4-bit.
  - Outputs: 2-bit leading-zero count and an all-zero flag.
- Top-level combine:
  - Instantiate 8 `clz_nibble` units, one per nibble.
  - Merge them with a 3-level tree of pairwise combines: 8→4→2→1.
  - Each combine selects the upper half's count if the upper half is non-zero; otherwise it takes the upper half's full width plus the lower half's count.
  - The final all-zero flag forces 32.
- The output register stage lives in the top module only.

## Test plan
- Reset: hold `rst_n` low, toggle `data_in`/`in_valid` → `out_valid = 0`, `count = 0` throughout. Release, then apply `0xFFFFFFFF` → `count = 0` one cycle later.
- Zero input: `data_in = 0x00000000` → `count = 32`, `zero = 1`.
- Single bit walk: for k = 0..31 apply `1 << k` → `count = 31 − k`, `zero = 0`.
- ctz via reversal: bench reverses operand bits before driving `data_in`. Expected counts:
  - `0x01800000` → 23
  - `0x0F31C7B0` → 4
  - `0x2F01C622` → 1
  - `0xFFFFFFFF` → 0
  - `0x00000000` → 32
- Mixed/random: 10k random operands, including sparse patterns such as `0x00000001` → 31 and `0x00010000` → 15. Compare against a loop-based reference model. Check 1-cycle latency and that `out_valid` follows `in_valid` delayed by one cycle, including back-to-back and gapped valids.
- Mid-stream reset: assert `rst_n` low asynchronously between clock edges while `in_valid = 1` → outputs clear immediately. No stale result appears after release.

Source files
------------

// File: rtl/zbb_pkg.sv
// Shared constants and types for the Zbb bit-count datapath.
package zbb_pkg;

  localparam int XLEN  = 32;
  localparam int CLZ_W = 6;
  localparam int NIB_N = XLEN / 4;

  typedef logic [CLZ_W-1:0] clz_cnt_t;

endpackage : zbb_pkg

// File: rtl/clz_encoder_if.sv
// Operand/result bundle for the leading-zero counter.
// The master side presents operands; the slave side returns registered results.
interface clz_encoder_if;
  import zbb_pkg::*;

  logic            in_valid;
  logic [XLEN-1:0] data_in;
  logic            out_valid;
  clz_cnt_t        count;
  logic            zero;

  modport master (
    output in_valid, data_in,
    input  out_valid, count, zero
  );

  modport slave (
    input  in_valid, data_in,
    output out_valid, count, zero
  );

endinterface : clz_encoder_if

// File: rtl/clz_nibble.sv
// Leading-zero count of a single nibble: 2-bit count plus all-zero flag.
// For an all-zero nibble the count reads 3; the flag tells the parent to skip it.
module clz_nibble (
  input  logic [3:0] nib_i,
  output logic [1:0] cnt_o,
  output logic       zero_o
);

  // Two-level sum-of-products form of the 4->2 priority encode.
  assign cnt_o[1] = ~(nib_i[3] | nib_i[2]);
  assign cnt_o[0] = ~nib_i[3] & (nib_i[2] | ~nib_i[1]);
  assign zero_o   = ~|nib_i;

endmodule : clz_nibble

// File: rtl/clz_encoder.sv
// 32-bit count-leading-zeros with a registered result (one-cycle latency).
// Eight nibble encoders feed a 3-level pairwise merge tree (8->4->2->1),
// keeping the critical path logarithmic in the operand width.
module clz_encoder
  import zbb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  clz_encoder_if.slave      bus
);

  // Per-nibble results; index 7 is the most significant nibble.
  logic [1:0] nib_cnt  [NIB_N];
  logic       nib_zero [NIB_N];

  // Merge tree levels: each level halves the node count and widens the count by one bit.
  logic [2:0] l1_cnt  [4];
  logic       l1_zero [4];
  logic [3:0] l2_cnt  [2];
  logic       l2_zero [2];
  logic [4:0] l3_cnt;
  logic       l3_zero;

  clz_cnt_t   enc_cnt;

  clz_cnt_t   count_d,     count_q;
  logic       zero_d,      zero_q;
  logic       out_valid_d, out_valid_q;

  for (genvar g = 0; g < NIB_N; g++) begin : g_nib
    clz_nibble u_nib (
      .nib_i  (bus.data_in[4*g +: 4]),
      .cnt_o  (nib_cnt[g]),
      .zero_o (nib_zero[g])
    );
  end

  // A merge takes the upper count when the upper half has a set bit; otherwise
  // the result is the upper half's full width plus the lower count. Because each
  // half's width is a power of two, that sum is just the lower count with a
  // leading 1 prepended.
  for (genvar g = 0; g < 4; g++) begin : g_l1
    assign l1_zero[g] = nib_zero[2*g+1] & nib_zero[2*g];
    assign l1_cnt[g]  = nib_zero[2*g+1] ? {1'b1, nib_cnt[2*g]} : {1'b0, nib_cnt[2*g+1]};
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    assign l2_zero[g] = l1_zero[2*g+1] & l1_zero[2*g];
    assign l2_cnt[g]  = l1_zero[2*g+1] ? {1'b1, l1_cnt[2*g]} : {1'b0, l1_cnt[2*g+1]};
  end

  assign l3_zero = l2_zero[1] & l2_zero[0];
  assign l3_cnt  = l2_zero[1] ? {1'b1, l2_cnt[0]} : {1'b0, l2_cnt[1]};

  // An all-zero word would otherwise read 31; force the dedicated 32 encoding.
  assign enc_cnt = l3_zero ? clz_cnt_t'(XLEN) : {1'b0, l3_cnt};

  // Next-state for the output registers: capture on valid, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    count_d     = count_q;
    zero_d      = zero_q;
    out_valid_d = bus.in_valid;
    // NOTE: the hold path selects the register, not data_in, so an X operand on an idle cycle never reaches the outputs.
    if (bus.in_valid) begin
      count_d = enc_cnt;
      zero_d  = l3_zero;
    end
  end

  // Output register stage; asynchronous clear discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (!rst_n) begin
      count_q     <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.zero      = zero_q;

endmodule : clz_encoder

// File: tb/tb_clz_encoder.sv
// Scoreboard bench for clz_encoder: the driver queues expected counts from a
// bit-scanning reference model; a monitor compares whenever out_valid is high
// and checks that idle cycles hold the previous result.
module tb_clz_encoder;
  import zbb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clz_encoder_if bus ();

  clz_encoder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int exp_q[$];
  int hold_cnt  = 0;
  int hold_zero = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan from the MSB downward until the first set bit.
  function automatic int ref_clz(input logic [31:0] d);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  // Present one operand on the falling edge; queue its expected count if it will be captured.
  task automatic send(input logic v, input logic [31:0] d, input int exp);
    @(negedge clk);
    bus.in_valid = v;
    bus.data_in  = d;
    if (v && rst_n) exp_q.push_back(exp);
  endtask

  task automatic send_ref(input logic [31:0] d);
    send(1'b1, d, ref_clz(d));
  endtask

  task automatic idle();
    send(1'b0, 32'hxxxx_xxxx, 0);
  endtask

  // Monitor: after each rising edge, out_valid must mirror the in_valid seen at that edge.
  logic v_at_edge;
  always @(posedge clk) begin
    v_at_edge = bus.in_valid;
    #1;
    check("out_valid", longint'(bus.out_valid), longint'(v_at_edge && rst_n));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        hold_cnt  = exp_q.pop_front();
        hold_zero = (hold_cnt == 32) ? 1 : 0;
        check("count", longint'(bus.count), longint'(hold_cnt));
        check("zero", longint'(bus.zero), longint'(hold_zero));
      end
    end else begin
      check("hold_count", longint'(bus.count), longint'(hold_cnt));
      check("hold_zero", longint'(bus.zero), longint'(hold_zero));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] ctz_ops [5] = '{32'h0180_0000, 32'h0F31_C7B0, 32'h2F01_C622, 32'hFFFF_FFFF, 32'h0000_0000};
  int          ctz_exp [5] = '{23, 4, 1, 0, 32};

  initial begin
    bus.in_valid = 1'b0;
    bus.data_in  = '0;

    // Reset held low with activity on the inputs: outputs stay cleared.
    #1;
    check("reset_valid", longint'(bus.out_valid), 0);
    check("reset_count", longint'(bus.count), 0);
    check("reset_zero", longint'(bus.zero), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.data_in  = $urandom();
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // First capture after release.
    send_ref(32'hFFFF_FFFF);
    idle();

    // All-zero operand.
    send(1'b1, 32'h0000_0000, 32);
    idle();

    // Walking single bit, back-to-back.
    for (int k = 0; k < 32; k++) send(1'b1, 32'h1 << k, 31 - k);
    idle();

    // ctz through caller-side reversal, with fixed expected counts.
    for (int i = 0; i < 5; i++) send(1'b1, bit_rev(ctz_ops[i]), ctz_exp[i]);
    idle();

    // Sparse directed cases.
    send(1'b1, 32'h0000_0001, 31);
    send(1'b1, 32'h0001_0000, 15);
    idle();
    idle();

    // Random operands with random gaps.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom();
        1:       d = 32'h1 << $urandom_range(0, 31);
        2:       d = $urandom() >> $urandom_range(0, 31);
        default: d = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom() & $urandom() & $urandom());
      endcase
      if ($urandom_range(0, 4) == 0) idle();
      else                           send_ref(d);
    end
    idle();

    // Mid-stream asynchronous reset between edges while an operand is in flight.
    send_ref(32'h0000_0F00);
    send_ref(32'h0040_0000);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    hold_cnt  = 0;
    hold_zero = 0;
    #1;
    check("midrst_valid", longint'(bus.out_valid), 0);
    check("midrst_count", longint'(bus.count), 0);
    check("midrst_zero", longint'(bus.zero), 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = $urandom();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    idle();
    idle();
    send_ref(32'h0000_8000);
    send_ref(32'h8000_0000);
    idle();
    idle();

    check("queue_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clz_encoder
